sim_progress_monitor: RTL and testbench
=======================================

Name: sim_progress_monitor

Overview:
- Synthesizable multi-hart progress monitor for simulation tops.
- Counts cycles and retired instructions per hart from the ROB commit lanes (walk cycles excluded).
- Detects per-hart commit stalls and emits periodic report snapshots.
- Sits beside the simulated SoC in the testbench top; the top prints the snapshots and reacts to the stall flags.

Parameters:
- NUM_HARTS, 1, number of monitored harts.
- COMMIT_WIDTH, 6, commit lanes per hart.
- CNT_W, 64, width of the cycle and instruction counters.
- STUCK_LIMIT, 5000, maximum number of consecutive commit-less cycles tolerated per hart.
- REPORT_INTERVAL, 10000, cycles between report pulses; must be ≥2.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear of counters, timers, flags and FSM.
- commit_valid  in  NUM_HARTS*COMMIT_WIDTH  lane valids; hart h occupies bits [h*COMMIT_WIDTH +: COMMIT_WIDTH].
- commit_is_walk  in  NUM_HARTS  per hart: the current lanes are walk, not retire.
- cycle_count  out  CNT_W  cycles since reset/clear.
- instr_count  out  NUM_HARTS*CNT_W  retired instructions per hart.
- stuck  out  NUM_HARTS  sticky per-hart stall flag.
- fatal  out  1  one-cycle pulse on the first stall.
- state  out  2  FSM state: 0 RUN, 1 STUCK.
- report_valid  out  1  one-cycle report pulse.
- report_cycle  out  CNT_W  cycle_count snapshot.
- report_instr  out  NUM_HARTS*CNT_W  instr_count snapshot.

Behaviour:
- Reset:
  - All outputs 0; state = RUN.
  - Internal stuck timers and the interval counter are 0.
- clear:
  - Same effect as reset, applied synchronously.
  - Has priority over every other event in that cycle.
- Commit qualification, per hart h:
  - commits_h = popcount(lanes of h) when !commit_is_walk[h], else 0.
  - commits_h is 0..COMMIT_WIDTH, $clog2(COMMIT_WIDTH+1) bits wide, zero-extended to CNT_W.
- Counters:
  - instr_count[h] += commits_h every cycle.
  - cycle_count += 1 every cycle.
  - Both wrap modulo 2^CNT_W; no saturation.
- Stuck timer, per hart, width $clog2(STUCK_LIMIT+2):
  - Any qualified commit (commits_h ≠ 0) resets it to 0.
  - Otherwise it increments, saturating at STUCK_LIMIT+1.
  - Walk cycles with valid lanes count as commit-less.
- stuck[h]:
  - Set on the edge where the timer goes from STUCK_LIMIT to STUCK_LIMIT+1, i.e. the (STUCK_LIMIT+1)-th consecutive commit-less edge.
  - Sticky until reset or clear; later commits do not clear it.
  - Its timer keeps saturating.
- FSM:
  - RUN→STUCK when any stuck bit sets; fatal pulses high for exactly that one cycle, registered alongside the stuck bit.
  - STUCK holds; further harts setting stuck produce no new fatal.
  - STUCK→RUN only via clear or reset.
- Reports:
  - Internal down-counter loaded to REPORT_INTERVAL-1 at reset/clear.
  - The edge where cycle_count becomes k*REPORT_INTERVAL (k≥1) also registers report_valid=1, report_cycle=that value and report_instr=the instr_count values written on that same edge.
  - So during the pulse cycle, report_* equal the live cycle_count/instr_count outputs.
  - report_valid is low otherwise; the snapshot holds until the next report.
  - No report at cycle 0.
  - Reports continue in the STUCK state.
  - Report timing is independent of cycle_count wrap.
- Simultaneous events:
  - Commit and saturation on the same edge: the commit wins; the timer goes to 0 and stuck does not set.
  - Report and stall on the same edge: both are emitted.

Optional Feature:
- Macro: SIM_PROGRESS_IPC_EN.
- Defined:
  - Extra output report_window  out  CNT_W: total commits summed over all harts during the REPORT_INTERVAL cycles ending at the report edge, including that edge's commits.
  - Updated together with report_valid.
  - Internal window accumulator restarts at 0 after each report and on reset/clear.
- Undefined: the port and the accumulator are absent; all other behaviour is identical.

Test Plan:
- NUM_HARTS=1, STUCK_LIMIT=8; reset release, no commits:
  - stuck=0 through the 8th edge; stuck=1 and fatal=1 on the 9th edge; fatal=0 on the 10th; state=1.
- Lanes 0b000111 every cycle for 5 cycles, then 0b111111 with is_walk=1 for 3 cycles → instr_count=15 and stays 15.
- REPORT_INTERVAL=16, 2 commits/cycle from reset:
  - report_valid pulses when cycle_count=16 (report_instr=32) and at 32 (report_instr=64).
  - No pulse at cycle_count=0.
  - With SIM_PROGRESS_IPC_EN: report_window=32 both times.
- NUM_HARTS=2, STUCK_LIMIT=8; hart0 commits every cycle, hart1 never:
  - stuck=0b10, one fatal pulse.
  - Hart0 later starved 9 cycles → stuck=0b11, no second fatal.
- Stuck set, then clear for one cycle:
  - All counters 0, stuck=0, state=RUN, report_valid=0.
  - Next report at cycle_count=16.
- Commit on the edge the timer would reach 9 (STUCK_LIMIT=8):
  - Timer resets to 0, stuck stays 0.
- Asynchronous reset asserted mid-cycle while stuck=1 → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sim_progress_monitor.sv
// sim_progress_monitor
//
// Multi-hart progress monitor that sits beside the simulated SoC in a
// simulation top. It counts cycles and retired instructions per hart from the
// ROB commit lanes. Lanes flagged as walk do not count as retirement. It also
// detects per-hart commit stalls and produces a periodic snapshot of the
// counters for the top to print.
//
// Optional feature: define SIM_PROGRESS_IPC_EN to add the report_window output.
// report_window holds the total commits over all harts during the report
// interval that ends at each report edge. When the macro is undefined, the port
// and its accumulator are absent.
//
// Ports:
//   clock          in   system clock
//   reset          in   asynchronous, active-high reset
//   clear          in   synchronous clear of counters, timers, flags and FSM
//   commit_valid   in   lane valids, hart h at [h*COMMIT_WIDTH +: COMMIT_WIDTH]
//   commit_is_walk in   per hart: current lanes are a walk, not retirement
//   cycle_count    out  cycles since reset/clear
//   instr_count    out  retired instructions per hart, hart h at [h*CNT_W +: CNT_W]
//   stuck          out  sticky per-hart stall flags
//   fatal          out  one-cycle pulse on the first stall
//   state          out  FSM state: 0 RUN, 1 STUCK
//   report_valid   out  one-cycle report pulse
//   report_cycle   out  cycle_count snapshot
//   report_instr   out  instr_count snapshot
//   report_window  out  (SIM_PROGRESS_IPC_EN only) commits in the last interval

module sim_progress_monitor #(
  parameter int NUM_HARTS       = 1,
  parameter int COMMIT_WIDTH    = 6,
  parameter int CNT_W           = 64,
  parameter int STUCK_LIMIT     = 5000,
  parameter int REPORT_INTERVAL = 10000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear,
  input  logic [NUM_HARTS*COMMIT_WIDTH-1:0] commit_valid,
  input  logic [NUM_HARTS-1:0]         commit_is_walk,
  output logic [CNT_W-1:0]             cycle_count,
  output logic [NUM_HARTS*CNT_W-1:0]   instr_count,
  output logic [NUM_HARTS-1:0]         stuck,
  output logic                         fatal,
  output logic [1:0]                   state,
  output logic                         report_valid,
  output logic [CNT_W-1:0]             report_cycle,
  output logic [NUM_HARTS*CNT_W-1:0]   report_instr
`ifdef SIM_PROGRESS_IPC_EN
  , output logic [CNT_W-1:0]           report_window
`endif
);

  localparam int CW = $clog2(COMMIT_WIDTH + 1);
  localparam int TW = $clog2(STUCK_LIMIT + 2);
  localparam int RW = $clog2(REPORT_INTERVAL);

  // Each timer saturates one step past the limit. The step from the limit to
  // the saturation value is the edge that raises the stuck flag.
  localparam logic [TW-1:0] TIMER_EDGE    = TW'(STUCK_LIMIT);
  localparam logic [TW-1:0] TIMER_SAT     = TW'(STUCK_LIMIT + 1);
  localparam logic [RW-1:0] INTERVAL_LOAD = RW'(REPORT_INTERVAL - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STUCK = 2'd1
  } state_t;

  state_t                             state_q, state_d;
  logic                               fatal_d;
  logic [NUM_HARTS-1:0][CW-1:0]       commits;
  logic [NUM_HARTS-1:0][CNT_W-1:0]    instr_q, instr_d;
  logic [NUM_HARTS-1:0][TW-1:0]       timer_q, timer_d;
  logic [NUM_HARTS-1:0]               stuck_q;
  logic [NUM_HARTS-1:0]               set_bits;
  logic [CNT_W-1:0]                   cycle_q, cycle_d;
  logic [CNT_W-1:0]                   total_commits;
  logic [RW-1:0]                      interval_q;
  logic                               report_due;
  logic                               report_valid_q;
  logic [CNT_W-1:0]                   report_cycle_q;
  logic [NUM_HARTS-1:0][CNT_W-1:0]    report_instr_q;

  // Qualify each hart's lanes. Walk cycles contribute no commits, even when
  // their lanes are valid.
  always_comb begin
    commits = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (!commit_is_walk[h]) begin
        for (int l = 0; l < COMMIT_WIDTH; l++) begin
          commits[h] = commits[h] + CW'(commit_valid[h*COMMIT_WIDTH + l]);
        end
      end
    end
  end

  // Next counter values. These values also feed the report snapshot, so a
  // report carries the counts written on its own edge.
  always_comb begin
    cycle_d       = cycle_q + CNT_W'(1);
    total_commits = '0;
    instr_d       = instr_q;
    for (int h = 0; h < NUM_HARTS; h++) begin
      instr_d[h]    = instr_q[h] + CNT_W'(commits[h]);
      total_commits = total_commits + CNT_W'(commits[h]);
    end
  end

  // Stall timers. A qualified commit always wins over saturation on the same
  // edge, so a hart that commits just in time never raises its flag.
  always_comb begin
    timer_d  = timer_q;
    set_bits = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (commits[h] != '0) begin
        timer_d[h] = '0;
      end else begin
        if (timer_q[h] == TIMER_EDGE) begin
          set_bits[h] = 1'b1;
        end
        if (timer_q[h] != TIMER_SAT) begin
          timer_d[h] = timer_q[h] + TW'(1);
        end
      end
    end
  end

  // The down-counter reaches zero on the edge where cycle_count becomes a
  // multiple of the interval. Because it never looks at cycle_count, report
  // timing does not depend on counter wrap.
  assign report_due = (interval_q == '0);

  // FSM next state. Only the first stall after reset or clear fires fatal. In
  // STUCK, later harts that stall update their own flags and nothing else.
  always_comb begin
    state_d = state_q;
    fatal_d = 1'b0;
    case (state_q)
      RUN: begin
        if (|set_bits) begin
          state_d = STUCK;
          fatal_d = 1'b1;
        end
      end
      STUCK: begin
        state_d = STUCK;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // FSM state register and the fatal pulse, which is registered alongside the
  // stuck flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      fatal   <= 1'b0;
    end else if (clear) begin
      state_q <= RUN;
      fatal   <= 1'b0;
    end else begin
      state_q <= state_d;
      fatal   <= fatal_d;
    end
  end

  // Cycle and per-hart instruction counters. Both wrap freely.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else if (clear) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_d;
      instr_q <= instr_d;
    end
  end

  // Stall timers and sticky flags. Later commits do not lower a flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
      stuck_q <= '0;
    end else if (clear) begin
      timer_q <= '0;
      stuck_q <= '0;
    end else begin
      timer_q <= timer_d;
      stuck_q <= stuck_q | set_bits;
    end
  end

  // Report interval counter and the snapshot registers. The snapshot holds
  // until the next report, and reports keep running in the STUCK state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      interval_q     <= INTERVAL_LOAD;
      report_valid_q <= 1'b0;
      report_cycle_q <= '0;
      report_instr_q <= '0;
    end else if (clear) begin
      interval_q     <= INTERVAL_LOAD;
      report_valid_q <= 1'b0;
      report_cycle_q <= '0;
      report_instr_q <= '0;
    end else begin
      report_valid_q <= report_due;
      if (report_due) begin
        interval_q     <= INTERVAL_LOAD;
        report_cycle_q <= cycle_d;
        report_instr_q <= instr_d;
      end else begin
        interval_q     <= interval_q - RW'(1);
      end
    end
  end

`ifdef SIM_PROGRESS_IPC_EN
  logic [CNT_W-1:0] window_acc_q;
  logic [CNT_W-1:0] window_sum;

  // The window includes the commits of the report edge itself. The
  // accumulator then restarts at zero for the next interval.
  assign window_sum = window_acc_q + total_commits;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      window_acc_q  <= '0;
      report_window <= '0;
    end else if (clear) begin
      window_acc_q  <= '0;
      report_window <= '0;
    end else if (report_due) begin
      window_acc_q  <= '0;
      report_window <= window_sum;
    end else begin
      window_acc_q  <= window_sum;
    end
  end
`else
  // Without the window accumulator, the total commit count feeds nothing.
  logic unused_total;
  assign unused_total = ^total_commits;
`endif

  assign cycle_count  = cycle_q;
  assign instr_count  = instr_q;
  assign stuck        = stuck_q;
  assign state        = state_q;
  assign report_valid = report_valid_q;
  assign report_cycle = report_cycle_q;
  assign report_instr = report_instr_q;

endmodule

// File: tb/tb_sim_progress_monitor.sv
// tb_sim_progress_monitor
//
// Self-checking bench for sim_progress_monitor. It is configured with two
// harts, six lanes, a stall limit of 8 and a report interval of 16. Every
// output is compared after each clock edge against a behavioural model that
// tracks totals, run lengths and report boundaries arithmetically.

module tb_sim_progress_monitor;

  localparam int NH  = 2;
  localparam int CWD = 6;
  localparam int CNT = 64;
  localparam int LIM = 8;
  localparam int RI  = 16;

  logic                 clock;
  logic                 reset;
  logic                 clear;
  logic [NH*CWD-1:0]    commit_valid;
  logic [NH-1:0]        commit_is_walk;
  logic [CNT-1:0]       cycle_count;
  logic [NH*CNT-1:0]    instr_count;
  logic [NH-1:0]        stuck;
  logic                 fatal;
  logic [1:0]           state;
  logic                 report_valid;
  logic [CNT-1:0]       report_cycle;
  logic [NH*CNT-1:0]    report_instr;
`ifdef SIM_PROGRESS_IPC_EN
  logic [CNT-1:0]       report_window;
`endif

  sim_progress_monitor #(
    .NUM_HARTS       (NH),
    .COMMIT_WIDTH    (CWD),
    .CNT_W           (CNT),
    .STUCK_LIMIT     (LIM),
    .REPORT_INTERVAL (RI)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .clear          (clear),
    .commit_valid   (commit_valid),
    .commit_is_walk (commit_is_walk),
    .cycle_count    (cycle_count),
    .instr_count    (instr_count),
    .stuck          (stuck),
    .fatal          (fatal),
    .state          (state),
    .report_valid   (report_valid),
    .report_cycle   (report_cycle),
    .report_instr   (report_instr)
`ifdef SIM_PROGRESS_IPC_EN
    , .report_window (report_window)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors;
  int miscompares;
  int fatal_seen;

  // Reference model state.
  logic [CNT-1:0] m_cycles;
  logic [CNT-1:0] m_instr [NH];
  int             m_run [NH];
  logic [NH-1:0]  m_stuck;
  logic           m_fatal;
  logic           m_rv;
  logic [CNT-1:0] m_rc;
  logic [CNT-1:0] m_ri [NH];
  logic [CNT-1:0] m_win;
  logic [CNT-1:0] m_rw;

  task automatic model_reset();
    m_cycles = '0;
    m_stuck  = '0;
    m_fatal  = 1'b0;
    m_rv     = 1'b0;
    m_rc     = '0;
    m_win    = '0;
    m_rw     = '0;
    for (int h = 0; h < NH; h++) begin
      m_instr[h] = '0;
      m_run[h]   = 0;
      m_ri[h]    = '0;
    end
  endtask

  // One clock edge of the model: count commits, measure commit-less run
  // lengths, and report whenever the cycle total reaches a multiple of RI.
  task automatic model_edge(input logic [NH*CWD-1:0] lanes, input logic [NH-1:0] walk,
                            input logic clr);
    logic          any_before;
    logic [CNT-1:0] total;
    logic [CWD-1:0] hl;
    int            c;
    if (clr) begin
      model_reset();
      return;
    end
    any_before = |m_stuck;
    total      = '0;
    for (int h = 0; h < NH; h++) begin
      hl = lanes[h*CWD +: CWD];
      c  = walk[h] ? 0 : $countones(hl);
      m_instr[h] = m_instr[h] + CNT'(c);
      total      = total + CNT'(c);
      if (c != 0) m_run[h] = 0;
      else        m_run[h] = m_run[h] + 1;
      if (m_run[h] == LIM + 1) m_stuck[h] = 1'b1;
    end
    m_fatal  = !any_before && (|m_stuck);
    m_cycles = m_cycles + CNT'(1);
    m_win    = m_win + total;
    if ((m_cycles % CNT'(RI)) == '0) begin
      m_rv = 1'b1;
      m_rc = m_cycles;
      for (int h = 0; h < NH; h++) m_ri[h] = m_instr[h];
      m_rw  = m_win;
      m_win = '0;
    end else begin
      m_rv = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    logic [NH*CNT-1:0] ei;
    logic [NH*CNT-1:0] eri;
    for (int h = 0; h < NH; h++) begin
      ei[h*CNT +: CNT]  = m_instr[h];
      eri[h*CNT +: CNT] = m_ri[h];
    end
    check("cycle_count",  256'(cycle_count),  256'(m_cycles));
    check("instr_count",  256'(instr_count),  256'(ei));
    check("stuck",        256'(stuck),        256'(m_stuck));
    check("fatal",        256'(fatal),        256'(m_fatal));
    check("state",        256'(state),        256'(2'(|m_stuck)));
    check("report_valid", 256'(report_valid), 256'(m_rv));
    check("report_cycle", 256'(report_cycle), 256'(m_rc));
    check("report_instr", 256'(report_instr), 256'(eri));
`ifdef SIM_PROGRESS_IPC_EN
    check("report_window", 256'(report_window), 256'(m_rw));
`endif
    if (fatal === 1'b1) fatal_seen++;
  endtask

  // Drive one cycle of inputs, advance both DUT and model by one edge, then
  // compare just after the edge.
  task automatic apply_stimulus(input logic [NH*CWD-1:0] lanes, input logic [NH-1:0] walk,
                                input logic clr);
    commit_valid   = lanes;
    commit_is_walk = walk;
    clear          = clr;
    @(posedge clock);
    model_edge(lanes, walk, clr);
    #1;
    check_output();
  endtask

  initial begin
    logic [NH*CWD-1:0] rl;
    logic [NH-1:0]     rw;
    logic              sparse;
    vectors        = 0;
    miscompares    = 0;
    fatal_seen     = 0;
    reset          = 1'b1;
    clear          = 1'b0;
    commit_valid   = '0;
    commit_is_walk = '0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check_output();
    @(negedge clock);
    reset = 1'b0;

    // No commits after reset release. Both harts stall on the 9th edge.
    for (int i = 1; i <= 10; i++) begin
      apply_stimulus('0, '0, 1'b0);
      if (i == 8) check("tp_stuck_at_8", 256'(stuck), 256'(2'b00));
      if (i == 9) begin
        check("tp_stuck_at_9", 256'(stuck), 256'(2'b11));
        check("tp_fatal_at_9", 256'(fatal), 256'(1'b1));
      end
      if (i == 10) begin
        check("tp_fatal_at_10", 256'(fatal), 256'(1'b0));
        check("tp_state_at_10", 256'(state), 256'(2'd1));
      end
    end

    // A one-cycle clear wipes everything.
    apply_stimulus('0, '0, 1'b1);
    check("tp_clear_stuck", 256'(stuck), 256'(2'b00));

    // Three lanes for five cycles, then a full-width walk for three cycles.
    for (int i = 0; i < 5; i++) apply_stimulus({6'b000001, 6'b000111}, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) apply_stimulus({6'b000001, 6'b111111}, 2'b01, 1'b0);
    check("tp_walk_instr0", 256'(instr_count[CNT-1:0]), 256'(64'd15));

    // Two commits per cycle on hart 0 from a clear. Reports come at 16 and 32.
    apply_stimulus('0, '0, 1'b1);
    for (int i = 1; i <= 32; i++) begin
      apply_stimulus({6'b000000, 6'b000011}, 2'b00, 1'b0);
      if (i == 1) check("tp_no_early_report", 256'(report_valid), 256'(1'b0));
      if (i == 16 || i == 32) begin
        check("tp_report_valid", 256'(report_valid), 256'(1'b1));
        check("tp_report_instr0", 256'(report_instr[CNT-1:0]), 256'(64'(2 * i)));
`ifdef SIM_PROGRESS_IPC_EN
        check("tp_report_window", 256'(report_window), 256'(64'd32));
`endif
      end
    end

    // Hart 0 commits, hart 1 never. Then hart 0 starves as well.
    apply_stimulus('0, '0, 1'b1);
    fatal_seen = 0;
    for (int i = 0; i < 12; i++) apply_stimulus({6'b000000, 6'b000001}, 2'b00, 1'b0);
    check("tp_stuck_hart1", 256'(stuck), 256'(2'b10));
    for (int i = 0; i < 9; i++) apply_stimulus('0, '0, 1'b0);
    check("tp_stuck_both", 256'(stuck), 256'(2'b11));
    check("tp_single_fatal", 256'(fatal_seen), 256'(1));

    // A commit on the edge that would saturate the timer keeps the flag low.
    apply_stimulus('0, '0, 1'b1);
    for (int i = 0; i < 8; i++) apply_stimulus({6'b000001, 6'b000000}, 2'b00, 1'b0);
    apply_stimulus({6'b000001, 6'b100000}, 2'b00, 1'b0);
    check("tp_commit_wins", 256'(stuck), 256'(2'b00));
    for (int i = 0; i < 8; i++) apply_stimulus({6'b000001, 6'b000000}, 2'b00, 1'b0);
    check("tp_restart_8", 256'(stuck), 256'(2'b00));
    apply_stimulus({6'b000001, 6'b000000}, 2'b00, 1'b0);
    check("tp_restart_9", 256'(stuck), 256'(2'b01));

    // Randomized traffic that alternates dense and sparse phases, so stalls,
    // walks, reports and occasional clears all occur.
    sparse = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (i % 40 == 0) sparse = ($urandom_range(0, 1) == 1);
      for (int h = 0; h < NH; h++) begin
        if ($urandom_range(0, 9) < (sparse ? 9 : 3)) rl[h*CWD +: CWD] = '0;
        else rl[h*CWD +: CWD] = CWD'($urandom);
        rw[h] = ($urandom_range(0, 3) == 0);
      end
      apply_stimulus(rl, rw, ($urandom_range(0, 199) == 0));
    end

    // Force a stall, then assert reset in the middle of a cycle.
    apply_stimulus('0, '0, 1'b1);
    for (int i = 0; i < 9; i++) apply_stimulus('0, '0, 1'b0);
    check("tp_pre_reset_stuck", 256'(stuck), 256'(2'b11));
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_output();
    @(negedge clock);
    reset = 1'b0;
    apply_stimulus({6'b000001, 6'b000001}, 2'b00, 1'b0);

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
